// File: rtl/icache_pkg.sv
// Shared types and address-field widths for the direct-mapped instruction cache.
package icache_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int SETS_DEF       = 64;
  localparam int WORDS_DEF      = 4;

  localparam int WOFF_W = $clog2(WORDS_DEF);
  localparam int IDX_W  = $clog2(SETS_DEF);
  localparam int TAG_W  = DATA_WIDTH_DEF - IDX_W - WOFF_W - 2;

  typedef enum logic {
    IDLE,
    REFILL
  } fetch_state_e;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
  } line_addr_t;

endpackage

// File: rtl/icache_store.sv
// Tag, valid and data arrays: combinational read, synchronous writes and bulk invalidate.
module icache_store
  import icache_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int SETS       = SETS_DEF,
  parameter int WORDS      = WORDS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IDX_W-1:0]      rd_idx,
  input  logic [WOFF_W-1:0]     rd_woff,
  output logic                  rd_valid,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  tv_we,
  input  line_addr_t            tv_line,
  input  logic                  w_we,
  input  logic [IDX_W-1:0]      w_idx,
  input  logic [WOFF_W-1:0]     w_woff,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  clr_all
);

  logic [SETS-1:0]       valid;
  logic [TAG_W-1:0]      tags [SETS];
  logic [DATA_WIDTH-1:0] data [SETS][WORDS];

  // Bulk clear wins over a same-cycle line fill so a pending invalidate leaves the line invalid.
  always_ff @(posedge clk) begin
    if (rst || clr_all) begin
      valid <= '0;
    end else if (tv_we) begin
      valid[tv_line.idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tv_we) begin
      tags[tv_line.idx] <= tv_line.tag;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      data[w_idx][w_woff] <= w_data;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_data  = data[rd_idx][rd_woff];

endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped instruction cache in the fetch stage: zero-latency hits, blocking
// line refill from word 0 over a single-outstanding word-read memory port.
module icache_fetch
  import icache_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int SETS       = SETS_DEF,
  parameter int WORDS      = WORDS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pcF,
  output logic [DATA_WIDTH-1:0] instrF,
  output logic                  stallF,
  input  logic                  inv,
  output logic                  mem_req,
  output logic [DATA_WIDTH-1:0] mem_addr,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  fetch_state_e          state;
  logic [WOFF_W-1:0]     cnt;
  logic                  inv_pend;
  line_addr_t            lat_line;
  logic                  mem_req_q;

  logic [WOFF_W-1:0]     pc_woff;
  logic [IDX_W-1:0]      pc_idx;
  logic [TAG_W-1:0]      pc_tag;
  logic                  unused_byte_off;

  logic                  rd_valid;
  logic [TAG_W-1:0]      rd_tag;
  logic [DATA_WIDTH-1:0] rd_data;

  logic                  hit;
  logic                  last_word;
  logic                  accept;
  logic                  done;
  logic                  clr_all;

  assign pc_woff         = pcF[WOFF_W+1:2];
  assign pc_idx          = pcF[IDX_W+WOFF_W+1:WOFF_W+2];
  assign pc_tag          = pcF[DATA_WIDTH-1:IDX_W+WOFF_W+2];
  assign unused_byte_off = ^pcF[1:0];

  assign hit       = rd_valid && (rd_tag == pc_tag);
  assign last_word = (cnt == WOFF_W'(WORDS - 1));
  assign accept    = (state == REFILL) && mem_rvalid && !rst;
  assign done      = accept && last_word;
  // An invalidate seen at any point of a refill (including its last beat) kills the whole cache.
  assign clr_all   = ((state == IDLE) && inv) || (done && (inv_pend || inv));

  icache_store #(
    .DATA_WIDTH(DATA_WIDTH),
    .SETS      (SETS),
    .WORDS     (WORDS)
  ) u_store (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (pc_idx),
    .rd_woff (pc_woff),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .tv_we   (done),
    .tv_line (lat_line),
    .w_we    (accept),
    .w_idx   (lat_line.idx),
    .w_woff  (cnt),
    .w_data  (mem_rdata),
    .clr_all (clr_all)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      inv_pend  <= 1'b0;
      lat_line  <= '0;
      mem_req_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!hit) begin
            lat_line  <= '{tag: pc_tag, idx: pc_idx};
            cnt       <= '0;
            mem_req_q <= 1'b1;
            state     <= REFILL;
          end
        end
        REFILL: begin
          if (inv) begin
            inv_pend <= 1'b1;
          end
          if (mem_rvalid) begin
            cnt <= cnt + 1'b1;
            if (last_word) begin
              inv_pend  <= 1'b0;
              mem_req_q <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stallF   = !rst && ((state == REFILL) || !hit);
  assign instrF   = rst ? '0 : rd_data;
  assign mem_req  = mem_req_q && !rst;
  assign mem_addr = {lat_line, cnt, 2'b00};

endmodule

// File: tb/tb_icache_fetch.sv
// Scoreboard bench for icache_fetch: directed scenarios plus random fetch streams
// checked against a line-level cache model and a latency-programmable memory.
module tb_icache_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] pcF;
  logic [31:0] instrF;
  logic        stallF;
  logic        inv;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  icache_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .pcF       (pcF),
    .instrF    (instrF),
    .stallF    (stallF),
    .inv       (inv),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    int          stalls;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] addr_q[$];
  logic [31:0] mem_ovr[logic [31:0]];

  bit          m_vld[64];
  logic [27:0] m_line[64];

  int n_vec = 0;
  int n_mis = 0;
  int cur_lat = 0;
  bit spur = 0;
  bit done = 0;
  int stall_cnt = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 64; i++) m_vld[i] = 0;
  endfunction

  function automatic void push_line(input logic [27:0] line);
    for (int w = 0; w < 4; w++) addr_q.push_back({line, 4'b0000} + 32'(4 * w));
  endfunction

  // Memory: answers each request after cur_lat wait cycles, one word at a time.
  initial begin
    int          wait_cnt;
    logic [31:0] held;
    wait_cnt   = 0;
    held       = '0;
    mem_rvalid = 0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      mem_rvalid = 0;
      if (spur) begin
        mem_rvalid = 1;
        mem_rdata  = 32'hDEAD_BEEF;
      end else if (mem_req) begin
        if (wait_cnt == 0) held = mem_addr;
        else chk("mem_addr_hold", mem_addr, held);
        if (wait_cnt >= cur_lat) begin
          if (addr_q.size() == 0) begin
            chk("unexpected_mem_req", mem_addr, 32'hFFFF_FFFF);
          end else begin
            chk("mem_addr", mem_addr, addr_q.pop_front());
          end
          mem_rvalid = 1;
          mem_rdata  = memf(mem_addr);
          wait_cnt   = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: a delivered instruction is any non-stalled cycle while a fetch is outstanding.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_cnt = 0;
      end else if (sb.size() > 0) begin
        if (stallF) begin
          stall_cnt++;
        end else begin
          e = sb.pop_front();
          chk($sformatf("instrF@%h", e.pc), instrF, e.instr);
          chk($sformatf("stall_cycles@%h", e.pc), 32'(stall_cnt), 32'(e.stalls));
          chk("mem_req_when_delivering", {31'b0, mem_req}, 32'h0);
          stall_cnt = 0;
          done = 1;
        end
      end
    end
  end

  // Issue one fetch at posedge+1; inv_at pulses inv in that cycle of the fetch (0 = first cycle).
  task automatic fetch(input logic [31:0] pc, input int lat, input int inv_at, input bit spur0);
    exp_t        e;
    logic [27:0] line;
    int          idx;
    int          r;
    int          c;
    line = pc[31:4];
    idx  = int'(line % 64);
    r    = 4 * (lat + 1);
    e.pc    = pc;
    e.instr = memf({pc[31:2], 2'b00});
    if (m_vld[idx] && m_line[idx] == line) begin
      e.stalls = 0;
      if (inv_at == 0) model_clear();
    end else begin
      e.stalls = 1 + r;
      push_line(line);
      if (inv_at >= 1 && inv_at <= r) begin
        e.stalls += 1 + r;
        push_line(line);
      end
      if (inv_at >= 0 && inv_at <= r) model_clear();
      m_vld[idx]  = 1;
      m_line[idx] = line;
    end
    cur_lat = lat;
    done    = 0;
    pcF     = pc;
    sb.push_back(e);
    c = 0;
    forever begin
      inv  = (c == inv_at);
      spur = spur0 && (c == 0);
      @(posedge clk);
      #1;
      c++;
      if (done) break;
      if (c > 200) begin
        n_vec++;
        n_mis++;
        $display("FAIL fetch_timeout@%h: no delivery after %0d cycles", pc, c);
        $fatal(1, "fetch timeout");
      end
    end
    inv  = 0;
    spur = 0;
  endtask

  task automatic do_reset(input int n);
    rst = 1;
    repeat (n) begin
      @(negedge clk);
      chk("rst_stallF", {31'b0, stallF}, 32'h0);
      chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
      chk("rst_instrF", instrF, 32'h0);
      @(posedge clk);
      #1;
    end
    rst = 0;
    model_clear();
    addr_q.delete();
    sb.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] tagv[4];
    rst = 1;
    pcF = '0;
    inv = 0;
    mem_ovr[32'h0] = 32'hA0;
    mem_ovr[32'h4] = 32'hA1;
    mem_ovr[32'h8] = 32'hA2;
    mem_ovr[32'hC] = 32'hA3;
    @(posedge clk);
    #1;
    do_reset(2);

    // Cold miss with one-cycle memory, then the rest of the line hits.
    fetch(32'h0, 0, -1, 0);
    for (int w = 1; w < 4; w++) fetch(32'(4 * w), 0, -1, 0);

    // Hit sweep, with stray mem_rvalid pulses while idle.
    fetch(32'h40, 0, -1, 0);
    for (int w = 0; w < 4; w++) fetch(32'h40 + 32'(4 * w), 0, -1, 1);

    // Conflict on index 0.
    fetch(32'h000, 0, -1, 0);
    fetch(32'h400, 0, -1, 0);
    fetch(32'h000, 0, -1, 0);

    // Slow memory.
    fetch(32'h808, 3, -1, 0);
    fetch(32'h80C, 3, -1, 0);

    // Invalidate mid-refill, on the final beat, and while idle.
    fetch(32'hC04, 0, 3, 0);
    fetch(32'hC04, 0, -1, 0);
    fetch(32'h1000, 1, 8, 0);
    fetch(32'h1004, 0, -1, 0);
    fetch(32'hC04, 0, 0, 0);
    fetch(32'hC04, 0, -1, 0);

    // Reset after the second word of a refill.
    cur_lat = 0;
    pcF = 32'h2000;
    addr_q.push_back(32'h2000);
    addr_q.push_back(32'h2004);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    spur = 1;
    do_reset(2);
    spur = 0;
    chk("addr_q_empty_after_rst", 32'(addr_q.size()), 32'h0);
    fetch(32'h2000, 0, -1, 0);
    fetch(32'h200C, 0, -1, 0);

    // Random streams over a small conflicting address pool.
    tagv[0] = 32'h0;
    tagv[1] = 32'h1;
    tagv[2] = 32'h3FFFFF;
    tagv[3] = 32'h2A5;
    for (int i = 0; i < 250; i++) begin
      logic [31:0] pc;
      int          lat;
      int          ia;
      pc  = (tagv[$urandom_range(0, 3)] << 10) | (32'($urandom_range(0, 7)) << 4)
            | (32'($urandom_range(0, 3)) << 2);
      lat = $urandom_range(0, 3);
      ia  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4 * (lat + 1)) : -1;
      fetch(pc, lat, ia, $urandom_range(0, 7) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
